// File: rtl/prog_delay_line.sv
// Programmable delay line: circular buffer of MAX_DEPTH samples (data plus valid)
// with a runtime-loadable delay of 1..MAX_DEPTH advance cycles and a gated, registered output.
module prog_delay_line #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_DEPTH = 32,
  localparam int SW        = $clog2(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [SW-1:0]    delay_sel,
  input  logic             delay_load,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             primed,
  output logic [SW-1:0]    delay_cur
);

  logic [WIDTH:0]   mem_q [MAX_DEPTH];
  logic [SW-1:0]    wp_q, wp_d;
  logic [SW-1:0]    delay_q, delay_d;
  logic [SW:0]      fill_q, fill_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             primed_q, primed_d;

  logic [SW:0]      depth;
  logic [SW-1:0]    rd_ptr;
  logic [WIDTH:0]   rd_word;
  logic             full;
  logic             wr_en;

  // Fill count saturates at the active depth.
  function automatic logic [SW:0] fill_step(input logic [SW:0] f, input logic [SW:0] lim);
    return (f >= lim) ? lim : f + (SW+1)'(1);
  endfunction

  // Read D entries behind the write pointer; at D = MAX_DEPTH this is the
  // entry being overwritten this cycle, read before the write lands.
  assign depth   = {1'b0, delay_q} + (SW+1)'(1);
  assign rd_ptr  = wp_q - delay_q - SW'(1);
  assign rd_word = mem_q[rd_ptr];
  assign full    = (fill_q == depth);
  assign wr_en   = en & ~reset;

  always_comb begin
    wp_d        = wp_q;
    delay_d     = delay_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    primed_d    = primed_q;
    if (delay_load) begin
      // New regime: the sample written on this edge (if any) is fill count 1.
      delay_d     = delay_sel;
      fill_d      = en ? (SW+1)'(1) : '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      primed_d    = 1'b0;
      if (en) wp_d = wp_q + SW'(1);
    end else if (en) begin
      wp_d        = wp_q + SW'(1);
      fill_d      = fill_step(fill_q, depth);
      primed_d    = full;
      out_data_d  = full ? rd_word[WIDTH-1:0] : '0;
      out_valid_d = full ? rd_word[WIDTH] : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q        <= '0;
      delay_q     <= SW'(MAX_DEPTH - 1);
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      delay_q     <= delay_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      primed_q    <= primed_d;
    end
  end

  // Storage is never reset; stale entries are masked until the line is full.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= {in_valid, in_data};
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;
  assign delay_cur = delay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed-vector bench for prog_delay_line: reset, basic delay, freeze, reload,
// depth-1, max depth with pointer wrap, and reset mid-operation.
module tb_prog_delay_line;

  localparam int WIDTH = 8;
  localparam int MAXD  = 32;
  localparam int SW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [SW-1:0]    delay_sel;
  logic             delay_load;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             primed;
  logic [SW-1:0]    delay_cur;

  int total = 0;
  int bad   = 0;

  prog_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAXD)) dut (
    .clk(clk), .reset(reset), .en(en), .in_data(in_data), .in_valid(in_valid),
    .delay_sel(delay_sel), .delay_load(delay_load), .out_data(out_data),
    .out_valid(out_valid), .primed(primed), .delay_cur(delay_cur)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [SW-1:0] sel);
    delay_sel = sel; delay_load = 1'b1; en = 1'b0;
    tick();
    delay_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; delay_load = 1'b1; delay_sel = 5'd3; en = 1'b1;
    in_data = 8'h55; in_valid = 1'b1;
    tick(); tick();
    total++;
    if ({out_valid, out_data, primed} !== {1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL reset_out got v=%b d=%h p=%b want 0/00/0", out_valid, out_data, primed);
    end
    total++;
    if (delay_cur !== 5'd31) begin
      bad++; $display("FAIL reset_delay got %0d want 31", delay_cur);
    end
    reset = 1'b0; delay_load = 1'b0; en = 1'b0;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] ed;
    logic ev;
    load_idle(5'd4);
    total++;
    if (delay_cur !== 5'd4) begin
      bad++; $display("FAIL basic_load got %0d want 4", delay_cur);
    end
    en = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_data = 8'(k);
      tick();
      ev = (k >= 6);
      ed = ev ? 8'(k - 5) : 8'h00;
      total++;
      if ({out_valid, out_data, primed} !== {ev, ed, ev}) begin
        bad++; $display("FAIL basic k=%0d got v=%b d=%h p=%b want v=%b d=%h p=%b",
                        k, out_valid, out_data, primed, ev, ed, ev);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_freeze();
    load_idle(5'd2);
    en = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_data = 8'(100 + k);
      tick();
    end
    total++;
    if ({out_valid, out_data} !== {1'b1, 8'd103}) begin
      bad++; $display("FAIL freeze_pre got v=%b d=%0d want 1/103", out_valid, out_data);
    end
    en = 1'b0; in_data = 8'hEE; in_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      total++;
      if ({out_valid, out_data, primed} !== {1'b1, 8'd103, 1'b1}) begin
        bad++; $display("FAIL freeze_hold c=%0d got v=%b d=%0d p=%b want 1/103/1",
                        c, out_valid, out_data, primed);
      end
    end
    en = 1'b1; in_valid = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      in_data = 8'(100 + k);
      tick();
      total++;
      if ({out_valid, out_data} !== {1'b1, 8'(97 + k)}) begin
        bad++; $display("FAIL freeze_resume k=%0d got v=%b d=%0d want 1/%0d",
                        k, out_valid, out_data, 97 + k);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reload();
    load_idle(5'd7);
    en = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_data = 8'(8'h40 + k);
      tick();
    end
    total++;
    if ({out_valid, out_data} !== {1'b1, 8'h44}) begin
      bad++; $display("FAIL reload_pre got v=%b d=%h want 1/44", out_valid, out_data);
    end
    delay_sel = 5'd1; delay_load = 1'b1; in_data = 8'h60;
    tick();
    delay_load = 1'b0;
    total++;
    if ({out_valid, out_data, primed, delay_cur} !== {1'b0, 8'h00, 1'b0, 5'd1}) begin
      bad++; $display("FAIL reload_edge got v=%b d=%h p=%b dc=%0d want 0/00/0/1",
                      out_valid, out_data, primed, delay_cur);
    end
    in_data = 8'h61;
    tick();
    total++;
    if ({out_valid, out_data, primed} !== {1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL reload_gap got v=%b d=%h p=%b want 0/00/0", out_valid, out_data, primed);
    end
    for (int k = 2; k <= 5; k++) begin
      in_data = 8'(8'h60 + k);
      tick();
      total++;
      if ({out_valid, out_data, primed} !== {1'b1, 8'(8'h60 + k - 2), 1'b1}) begin
        bad++; $display("FAIL reload_stream k=%0d got v=%b d=%h p=%b want 1/%h/1",
                        k, out_valid, out_data, primed, 8'(8'h60 + k - 2));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_depth1();
    delay_sel = 5'd0; delay_load = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick();
    delay_load = 1'b0;
    total++;
    if ({out_valid, out_data} !== {1'b0, 8'h00}) begin
      bad++; $display("FAIL d1_load got v=%b d=%h want 0/00", out_valid, out_data);
    end
    in_data = 8'h12; in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, out_data, primed} !== {1'b1, 8'h11, 1'b1}) begin
      bad++; $display("FAIL d1_first got v=%b d=%h p=%b want 1/11/1", out_valid, out_data, primed);
    end
    in_data = 8'h13; in_valid = 1'b1;
    tick();
    total++;
    if ({out_valid, out_data} !== {1'b0, 8'h12}) begin
      bad++; $display("FAIL d1_second got v=%b d=%h want 0/12", out_valid, out_data);
    end
    en = 1'b0; in_data = 8'hFF;
    tick();
    total++;
    if ({out_valid, out_data} !== {1'b0, 8'h12}) begin
      bad++; $display("FAIL d1_hold got v=%b d=%h want 0/12", out_valid, out_data);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH:0] hist [100];
    logic [WIDTH-1:0] ed;
    logic ev, ep;
    reset = 1'b1; tick(); reset = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data  = 8'(k * 7 + 3);
      in_valid = (k % 2 == 0);
      hist[k]  = {in_valid, in_data};
      tick();
      ep = (k >= 32);
      ev = ep ? hist[k - 32][WIDTH] : 1'b0;
      ed = ep ? hist[k - 32][WIDTH-1:0] : 8'h00;
      total++;
      if ({out_valid, out_data, primed} !== {ev, ed, ep}) begin
        bad++; $display("FAIL wrap k=%0d got v=%b d=%h p=%b want v=%b d=%h p=%b",
                        k, out_valid, out_data, primed, ev, ed, ep);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] ed;
    logic ev;
    load_idle(5'd5);
    en = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = 8'(8'h80 + k);
      tick();
    end
    total++;
    if ({out_valid, out_data} !== {1'b1, 8'h84}) begin
      bad++; $display("FAIL rmid_pre got v=%b d=%h want 1/84", out_valid, out_data);
    end
    reset = 1'b1; delay_load = 1'b1; delay_sel = 5'd3; in_data = 8'h9F;
    tick();
    reset = 1'b0; delay_load = 1'b0;
    total++;
    if ({out_valid, out_data, primed, delay_cur} !== {1'b0, 8'h00, 1'b0, 5'd31}) begin
      bad++; $display("FAIL rmid_reset got v=%b d=%h p=%b dc=%0d want 0/00/0/31",
                      out_valid, out_data, primed, delay_cur);
    end
    for (int k = 1; k <= 35; k++) begin
      in_data = 8'(8'hA0 + k);
      tick();
      ev = (k >= 33);
      ed = ev ? 8'(8'hA0 + k - 32) : 8'h00;
      total++;
      if ({out_valid, out_data} !== {ev, ed}) begin
        bad++; $display("FAIL rmid_after k=%0d got v=%b d=%h want v=%b d=%h",
                        k, out_valid, out_data, ev, ed);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; in_data = '0; in_valid = 1'b0;
    delay_sel = '0; delay_load = 1'b0;
    test_reset();
    test_basic();
    test_freeze();
    test_reload();
    test_depth1();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
